// File: rtl/sm_pkg.sv
// Shared types and Q4.11 format constants for the argmax scorer.
// Holds the FSM state enum and a helper for the class-index width.
package sm_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Q4.11 sign-magnitude: 1 sign, 4 integer, 11 fraction bits.
   localparam int Q_BITS    = 16;
   localparam int SIGN_BIT  = Q_BITS - 1;
   localparam int FRAC_BITS = 11;
   localparam int INT_BITS  = Q_BITS - 1 - FRAC_BITS;

   // Index width: max(1, clog2(n)).
   function automatic int cls_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sm_compare.sv
// Sign-magnitude strict greater-than: gt_o = (a_i > b_i).
// Ports: a_i, b_i scores (MSB = sign); gt_o result.
module sm_compare #(
   parameter int BITSIZE = 16
) (
   input  logic [BITSIZE-1:0] a_i,
   input  logic [BITSIZE-1:0] b_i,
   output logic               gt_o
);

   logic [BITSIZE-2:0] mag_a;
   logic [BITSIZE-2:0] mag_b;
   logic               neg_a;
   logic               neg_b;

   assign mag_a = a_i[BITSIZE-2:0];
   assign mag_b = b_i[BITSIZE-2:0];

   // -0 is folded onto +0 so both zeros compare equal.
   assign neg_a = a_i[BITSIZE-1] & (|mag_a);
   assign neg_b = b_i[BITSIZE-1] & (|mag_b);

   always_comb begin
      gt_o = 1'b0;
      unique case (1'b1)
         (!neg_a &&  neg_b): gt_o = 1'b1;
         ( neg_a && !neg_b): gt_o = 1'b0;
         (!neg_a && !neg_b): gt_o = (mag_a > mag_b);
         default:            gt_o = (mag_a < mag_b);
      endcase
   end

endmodule

// File: rtl/sm_argmax_scorer.sv
// Sequential argmax over NUM_CLASS sign-magnitude scores with
// accuracy counters. Ports: clk, reset (sync, high); in_valid/
// in_ready, scores, label (input side); out_valid/out_ready,
// pred_class, best_score, match (result side); clear, total_cnt,
// correct_cnt (counters).
module sm_argmax_scorer
   import sm_pkg::*;
#(
   parameter  int BITSIZE   = 16,
   parameter  int NUM_CLASS = 2,
   parameter  int CNT_W     = 16,
   localparam int CLS_W     = cls_w(NUM_CLASS)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [BITSIZE*NUM_CLASS-1:0] scores,
   input  logic [CLS_W-1:0]             label,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [CLS_W-1:0]             pred_class,
   output logic [BITSIZE-1:0]           best_score,
   output logic                         match,
   input  logic                         clear,
   output logic [CNT_W-1:0]             total_cnt,
   output logic [CNT_W-1:0]             correct_cnt
);

   localparam int VEC_W = BITSIZE * NUM_CLASS;
   localparam int TOP   = BITSIZE * (NUM_CLASS - 1);

   localparam logic [CLS_W-1:0] LAST_IDX =
      CLS_W'(NUM_CLASS - 1);
   localparam logic [CLS_W:0]   NC =
      (CLS_W + 1)'(NUM_CLASS);

   state_e             state_q;
   state_e             state_d;
   logic [VEC_W-1:0]   scores_q;
   logic [CLS_W-1:0]   label_q;
   logic [CLS_W-1:0]   idx_q;
   logic [CLS_W-1:0]   idx_d;
   logic [CLS_W-1:0]   pred_q;
   logic [CLS_W-1:0]   pred_d;
   logic [BITSIZE-1:0] best_q;
   logic [BITSIZE-1:0] best_d;
   logic [BITSIZE-1:0] cand;
   logic [CNT_W-1:0]   total_q;
   logic [CNT_W-1:0]   total_d;
   logic [CNT_W-1:0]   correct_q;
   logic [CNT_W-1:0]   correct_d;
   logic               gt;
   logic               cap;
   logic               hs;

   // Class k sits at bit offset BITSIZE*(NUM_CLASS-1-k).
   always_comb begin
      cand = scores_q[TOP +: BITSIZE];
      for (int k = 1; k < NUM_CLASS; k++) begin
         if (idx_q == CLS_W'(k)) begin
            cand = scores_q[BITSIZE*(NUM_CLASS-1-k) +: BITSIZE];
         end
      end
   end

   sm_compare #(
      .BITSIZE (BITSIZE)
   ) u_cmp (
      .a_i  (cand),
      .b_i  (best_q),
      .gt_o (gt)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pred_d  = pred_q;
      best_d  = best_q;
      cap     = 1'b0;
      hs      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               cap     = 1'b1;
               idx_d   = CLS_W'(1);
               pred_d  = '0;
               best_d  = scores[TOP +: BITSIZE];
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            // Strict '>' keeps the lower index on ties.
            if (gt) begin
               best_d = cand;
               pred_d = idx_q;
            end
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + CLS_W'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               hs      = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_ready   = (state_q == S_IDLE);
   assign out_valid  = (state_q == S_DONE);
   assign pred_class = pred_q;
   assign best_score = best_q;

   // Out-of-range labels (non power-of-two NUM_CLASS) never match.
   assign match = (pred_q == label_q) && ({1'b0, label_q} < NC);

   // Clear wins over a coincident handshake; both saturate.
   always_comb begin
      total_d   = total_q;
      correct_d = correct_q;
      if (clear) begin
         total_d   = '0;
         correct_d = '0;
      end else if (hs) begin
         if (!(&total_q)) begin
            total_d = total_q + CNT_W'(1);
         end
         if (match && !(&correct_q)) begin
            correct_d = correct_q + CNT_W'(1);
         end
      end
   end

   assign total_cnt   = total_q;
   assign correct_cnt = correct_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         pred_q    <= '0;
         best_q    <= '0;
         label_q   <= '0;
         scores_q  <= '0;
         total_q   <= '0;
         correct_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pred_q    <= pred_d;
         best_q    <= best_d;
         total_q   <= total_d;
         correct_q <= correct_d;
         if (cap) begin
            scores_q <= scores;
            label_q  <= label;
         end
      end
   end

endmodule

// File: tb/tb_sm_argmax_scorer.sv
// Self-checking bench for sm_argmax_scorer (NUM_CLASS=2 and 4).
// Table-driven vectors with a result scoreboard plus corner cases.
module tb_sm_argmax_scorer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // NUM_CLASS=2 instance
   logic        a_iv, a_ir, a_ov, a_or, a_clr, a_m;
   logic [31:0] a_sc;
   logic        a_lab, a_pc;
   logic [15:0] a_bs, a_tot, a_cor;

   // NUM_CLASS=4, CNT_W=4 instance
   logic        b_iv, b_ir, b_ov, b_or, b_clr, b_m;
   logic [63:0] b_sc;
   logic [1:0]  b_lab, b_pc;
   logic [15:0] b_bs;
   logic [3:0]  b_tot, b_cor;

   sm_argmax_scorer #(
      .BITSIZE(16), .NUM_CLASS(2), .CNT_W(16)
   ) u2 (
      .clk(clk), .reset(reset),
      .in_valid(a_iv), .in_ready(a_ir),
      .scores(a_sc), .label(a_lab),
      .out_valid(a_ov), .out_ready(a_or),
      .pred_class(a_pc), .best_score(a_bs),
      .match(a_m), .clear(a_clr),
      .total_cnt(a_tot), .correct_cnt(a_cor)
   );

   sm_argmax_scorer #(
      .BITSIZE(16), .NUM_CLASS(4), .CNT_W(4)
   ) u4 (
      .clk(clk), .reset(reset),
      .in_valid(b_iv), .in_ready(b_ir),
      .scores(b_sc), .label(b_lab),
      .out_valid(b_ov), .out_ready(b_or),
      .pred_class(b_pc), .best_score(b_bs),
      .match(b_m), .clear(b_clr),
      .total_cnt(b_tot), .correct_cnt(b_cor)
   );

   typedef struct {
      logic [63:0] sc;
      logic [1:0]  lab;
      logic [1:0]  pc;
      logic [15:0] bs;
      logic        m;
   } vec_t;

   typedef struct {
      logic [1:0]  pc;
      logic [15:0] bs;
      logic        m;
   } exp_t;

   vec_t tbl[7];
   exp_t sbq[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   tp_en   = 1'b0;
   int   last_acc = -1;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a sample until accepted; the result is queued for the monitor.
   task automatic send4(input vec_t v);
      int   k;
      exp_t e;
      k = 0;
      b_iv  = 1'b1;
      b_sc  = v.sc;
      b_lab = v.lab;
      while (!b_ir && k < 50) begin
         tick();
         k++;
      end
      if (k >= 50) chk("send4_timeout", 0, 1);
      e.pc = v.pc;
      e.bs = v.bs;
      e.m  = v.m;
      sbq.push_back(e);
      tick();
      b_iv = 1'b0;
      b_sc = ~v.sc;
   endtask

   task automatic wait_idle4();
      int k;
      k = 0;
      while ((!b_ir || sbq.size() != 0) && k < 100) begin
         tick();
         k++;
      end
      if (k >= 100) chk("idle_timeout", 0, 1);
   endtask

   task automatic wait_ov4();
      int k;
      k = 0;
      while (!b_ov && k < 20) begin
         tick();
         k++;
      end
      if (k >= 20) chk("ov_timeout", 0, 1);
   endtask

   // Scoreboard monitor and throughput check, sampled mid-cycle.
   always @(negedge clk) begin
      if (!reset && b_ov && b_or) begin
         if (sbq.size() == 0) begin
            chk("sb_empty", 1, 0);
         end else begin
            mon_e = sbq.pop_front();
            chk("sb_pred", b_pc, mon_e.pc);
            chk("sb_best", b_bs, mon_e.bs);
            chk("sb_match", b_m, mon_e.m);
         end
      end
      if (tp_en && b_iv && b_ir) begin
         if (last_acc >= 0) chk("throughput", cyc - last_acc, 5);
         last_acc = cyc;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      int   t0;
      int   k;
      bit   saw_ov;
      vec_t sat;

      tbl[0] = '{64'h8400_8200_8600_8100, 2'd3, 2'd3, 16'h8100, 1'b1};
      tbl[1] = '{64'h8000_0000_0000_8000, 2'd1, 2'd0, 16'h8000, 1'b0};
      tbl[2] = '{64'h0800_1000_1000_0C00, 2'd1, 2'd1, 16'h1000, 1'b1};
      tbl[3] = '{64'h8100_0000_7FFF_0001, 2'd2, 2'd2, 16'h7FFF, 1'b1};
      tbl[4] = '{64'h0001_8001_8000_0000, 2'd0, 2'd0, 16'h0001, 1'b1};
      tbl[5] = '{64'h8FFF_8FFF_8FFE_FFFF, 2'd0, 2'd2, 16'h8FFE, 1'b0};
      tbl[6] = '{64'h0000_8001_0000_8000, 2'd3, 2'd0, 16'h0000, 1'b0};

      reset = 1'b1;
      a_iv = 0; a_or = 0; a_clr = 0; a_sc = '0; a_lab = 0;
      b_iv = 0; b_or = 0; b_clr = 0; b_sc = '0; b_lab = '0;
      tick();
      tick();
      chk("rst_in_ready", b_ir, 1);
      chk("rst_out_valid", b_ov, 0);
      chk("rst_pred", b_pc, 0);
      chk("rst_best", b_bs, 0);
      chk("rst_total", b_tot, 0);
      chk("rst_correct", b_cor, 0);
      reset = 1'b0;
      tick();

      // NUM_CLASS=2: latency and basic argmax
      a_or  = 1'b1;
      a_sc  = {16'h0800, 16'h8800};
      a_lab = 1'b0;
      a_iv  = 1'b1;
      t0 = cyc;
      chk("a_in_ready", a_ir, 1);
      tick();
      a_iv = 1'b0;
      k = 0;
      while (!a_ov && k < 20) begin
         tick();
         k++;
      end
      chk("a_latency", cyc - t0, 2);
      chk("a_pred", a_pc, 0);
      chk("a_best", a_bs, 16'h0800);
      chk("a_match", a_m, 1);
      tick();
      chk("a_total1", a_tot, 1);
      chk("a_correct1", a_cor, 1);
      chk("a_ov_drop", a_ov, 0);

      a_sc = {16'h8800, 16'h0800};
      a_iv = 1'b1;
      tick();
      a_iv = 1'b0;
      k = 0;
      while (!a_ov && k < 20) begin
         tick();
         k++;
      end
      chk("a2_pred", a_pc, 1);
      chk("a2_best", a_bs, 16'h0800);
      chk("a2_match", a_m, 0);
      tick();
      chk("a_total2", a_tot, 2);
      chk("a_correct2", a_cor, 1);

      // NUM_CLASS=4 table, back to back with out_ready high
      b_or = 1'b1;
      tp_en = 1'b1;
      last_acc = -1;
      for (int i = 0; i < 7; i++) send4(tbl[i]);
      wait_idle4();
      tp_en = 1'b0;
      chk("tbl_total", b_tot, 7);
      chk("tbl_correct", b_cor, 4);

      // Backpressure: hold out_ready low for 5 DONE cycles
      b_or = 1'b0;
      t0 = cyc;
      send4(tbl[0]);
      wait_ov4();
      chk("b_latency", cyc - t0, 4);
      for (int i = 0; i < 5; i++) begin
         chk("hold_ov", b_ov, 1);
         chk("hold_ir", b_ir, 0);
         chk("hold_pred", b_pc, 3);
         chk("hold_best", b_bs, 16'h8100);
         chk("hold_match", b_m, 1);
         chk("hold_total", b_tot, 7);
         tick();
      end
      b_or = 1'b1;
      tick();
      chk("rel_total", b_tot, 8);
      chk("rel_correct", b_cor, 5);
      tick();
      chk("rel_total_once", b_tot, 8);

      // Reset on the 2nd SCAN cycle aborts the sample
      send4(tbl[2]);
      tick();
      reset = 1'b1;
      saw_ov = 1'b0;
      tick();
      reset = 1'b0;
      sbq.delete();
      chk("abort_ir", b_ir, 1);
      chk("abort_total", b_tot, 0);
      chk("abort_correct", b_cor, 0);
      for (int i = 0; i < 8; i++) begin
         if (b_ov) saw_ov = 1'b1;
         tick();
      end
      chk("abort_no_ov", saw_ov, 0);

      // Saturation at 15, then clear coincident with a handshake
      sat = '{64'h0800_0000_0000_0000, 2'd0, 2'd0, 16'h0800, 1'b1};
      for (int i = 0; i < 17; i++) send4(sat);
      wait_idle4();
      chk("sat_total", b_tot, 15);
      chk("sat_correct", b_cor, 15);
      send4(sat);
      wait_ov4();
      b_clr = 1'b1;
      tick();
      b_clr = 1'b0;
      chk("clr_total", b_tot, 0);
      chk("clr_correct", b_cor, 0);
      chk("clr_ir", b_ir, 1);

      // Clear during a scan leaves the FSM running
      send4(sat);
      b_clr = 1'b1;
      tick();
      b_clr = 1'b0;
      wait_idle4();
      chk("post_total", b_tot, 1);
      chk("post_correct", b_cor, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sm_argmax_scorer.md
SM_ARGMAX_SCORER -- requirements
Module: sm_argmax_scorer

Interface
REQ-001 SHALL have parameter BITSIZE, default 16, meaning the width of one sign-magnitude Q4.11 score (bit BITSIZE-1 is the sign).
REQ-002 SHALL have parameter NUM_CLASS, default 2, meaning the number of class scores per sample; legal range 2..16.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the width of the sample and correct counters.
REQ-004 SHALL derive localparam CLS_W = max(1, clog2(NUM_CLASS)).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit: a sample is offered.
REQ-008 SHALL have port in_ready, output, 1 bit: the block can accept a sample.
REQ-009 SHALL have port scores, input, BITSIZE*NUM_CLASS bits: class 0 in the MSBs, class NUM_CLASS-1 in the LSBs.
REQ-010 SHALL have port label, input, CLS_W bits: the true class of the offered sample.
REQ-011 SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port pred_class, output, CLS_W bits: the argmax index.
REQ-014 SHALL have port best_score, output, BITSIZE bits: the winning score.
REQ-015 SHALL have port match, output, 1 bit: pred_class equals the captured label.
REQ-016 SHALL have port clear, input, 1 bit: synchronous clear of the counters only.
REQ-017 SHALL have port total_cnt, output, CNT_W bits: the number of results consumed.
REQ-018 SHALL have port correct_cnt, output, CNT_W bits: the number of consumed results with match=1.

Function
REQ-019 SHALL implement an FSM with states IDLE, SCAN and DONE; in_ready=1 only in IDLE.
REQ-020 SHALL, on in_valid&&in_ready in IDLE: capture scores and label, set best = class 0, set idx = 1, and enter SCAN.
REQ-021 SHALL, in each SCAN cycle, compare score[idx] against best; if the comparison is strictly greater, update best and pred_class to idx; then increment idx.
REQ-022 SHALL, in SCAN when idx == NUM_CLASS-1, complete that compare and enter DONE.
REQ-023 SHALL set out_valid=1 exactly NUM_CLASS clocks after the accepting edge, i.e. after NUM_CLASS-1 SCAN cycles.
REQ-024 SHALL hold out_valid, pred_class, best_score and match stable in DONE until out_valid&&out_ready, then return to IDLE.
REQ-025 SHALL give a sustained throughput of one sample per NUM_CLASS+1 cycles when out_ready is held at 1.
REQ-026 SHALL compare in sign-magnitude: positive beats negative; among negatives the smaller magnitude is greater; among positives the larger magnitude is greater.
REQ-027 SHALL treat +0 and -0 as equal.
REQ-028 SHALL resolve ties (equal values) to the lower class index.
REQ-029 SHALL compute match combinationally from the registered pred_class and the captured label; a label >= NUM_CLASS can never match.
REQ-030 SHALL, on the result handshake, increment total_cnt, and also increment correct_cnt if match=1; each counter saturates at all-ones.
REQ-031 SHALL, on clear=1, zero both counters; clear does not disturb the FSM.
REQ-032 SHALL, when clear and a result handshake coincide, apply clear and drop that increment.
REQ-033 SHALL ignore in_valid and scores outside IDLE; the captured copy is used for the whole scan.

Reset
REQ-034 SHALL, on reset=1 at a clock edge, put the FSM in IDLE and zero idx, pred_class, best_score, total_cnt and correct_cnt; out_valid=0, in_ready=1.
REQ-035 SHALL let a reset during SCAN or DONE abort the sample: no counter update and no out_valid pulse.
REQ-036 SHALL give reset priority over clear and over both handshakes.

Structure
REQ-037 SHALL place the FSM state enum and the Q4.11 format constants (SIGN_BIT, FRAC_BITS=11) in shared package sm_pkg.
REQ-038 SHALL implement the greater-than test of REQ-026..028 in one combinational sub-module, sm_compare, parameterised by BITSIZE.

Verification
REQ-039 SHALL cover: NUM_CLASS=2, scores {0x0800 (+1.0), 0x8800 (-1.0)}, label 0 -> out_valid 2 clocks after accept, pred_class=0, match=1, correct_cnt=1.
REQ-040 SHALL cover: NUM_CLASS=4, scores {0x8400, 0x8200, 0x8600, 0x8100} (all negative), label 3 -> pred_class=3, best_score=0x8100, match=1.
REQ-041 SHALL cover: NUM_CLASS=4, scores {0x8000, 0x0000, 0x0000, 0x8000} (+/-0 ties) -> pred_class=0, best_score=0x8000.
REQ-042 SHALL cover: out_ready held 0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; total_cnt increments once on release.
REQ-043 SHALL cover: reset asserted on the 2nd SCAN cycle -> out_valid never rises, counters 0, in_ready=1 the next cycle.
REQ-044 SHALL cover: CNT_W=4, 17 matching samples, then clear coincident with the 18th handshake -> counts saturate at 15, then both read 0.
